// File: rtl/multi_arb_pkg.sv
// Shared types and constants for the multi-requester compute-unit arbiter.
// The index width covers the largest supported requester count.
package multi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  localparam int NREQ_MAX        = 8;
  localparam int IDXW            = $clog2(NREQ_MAX);
  localparam int DEFAULT_TIMEOUT = 15;

  // Successor of a requester index, wrapping modulo n.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/multi_unit_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping modulo NREQ.
module rr_pick
  import multi_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [NREQ-1:0] rot;

  always_comb begin
    int sum;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    rot = NREQ'({req, req} >> ptr);
    any = |req;
    idx = '0;
    sum = 0;
    // Descending scan: the smallest offset from ptr is written last and wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (rot[off]) begin
        sum = int'(ptr) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        idx = IDXW'(sum);
      end
    end
  end

endmodule

// File: rtl/multi_unit_arbiter.sv
// Shares one multi-cycle compute unit between NREQ valid/ready requesters,
// with a round-robin grant, a done watchdog and ownership of the unit reset.
module multi_unit_arbiter
  import multi_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_inp,
  output logic [NREQ-1:0] resp_valid,
  input  logic [NREQ-1:0] resp_ready,
  output logic [W-1:0]    resp_data,
  output logic            resp_err,
  output logic            unit_reset,
  output logic            unit_start,
  output logic [W-1:0]    unit_inp,
  input  logic            unit_done,
  input  logic [W-1:0]    unit_out,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t          state, state_nx;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant;
  logic [W-1:0]    operand;
  logic [CW-1:0]   wd_cnt;
  logic            reset_flag;

  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic            accept;
  logic            resp_fire;
  logic            timeout_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    resp_valid  = '0;
    unit_start  = 1'b0;
    accept      = 1'b0;
    resp_fire   = 1'b0;
    timeout_hit = (wd_cnt == CW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        // Requests are held off while the unit is still being reset.
        if (pick_any && !reset_flag) begin
          accept    = 1'b1;
          req_ready = NREQ'(1) << pick_idx;
          state_nx  = START;
        end
      end
      START: begin
        unit_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (unit_done)        state_nx = RESP;
        else if (timeout_hit) state_nx = RECOVER;
      end
      RECOVER: state_nx = RESP;
      RESP: begin
        resp_valid = NREQ'(1) << grant;
        if (((resp_ready >> grant) & NREQ'(1)) != '0) begin
          resp_fire = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      operand    <= '0;
      wd_cnt     <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      reset_flag <= 1'b1;
    end else begin
      state      <= state_nx;
      reset_flag <= 1'b0;
      if (accept) begin
        grant   <= pick_idx;
        operand <= req_inp[int'(pick_idx)*W +: W];
      end
      case (state)
        START: wd_cnt <= '0;
        WAIT: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          // Done takes priority over a simultaneous watchdog expiry.
          if (unit_done) begin
            resp_data <= unit_out;
            resp_err  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (resp_fire) rr_ptr <= next_idx(grant, NREQ);
    end
  end

  assign unit_reset = reset_flag | (state == RECOVER);
  assign unit_inp   = operand;
  assign busy       = (state != IDLE);

endmodule
